// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack game-control slice.
package blackjack_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEAL,
        S_PLAYER,
        S_HIT,
        S_CHECK,
        S_SHOW,
        S_DEALER,
        S_RESOLVE,
        S_SHOW_END
    } state_t;

    typedef logic [4:0] hand_t;

    localparam hand_t      BUST_LIMIT = 5'd21;
    localparam logic [3:0] CARD_MAX   = 4'd10;

    // Rank 0..12 maps to 1..10: ace is 1, the four top ranks are face cards worth 10.
    function automatic logic [3:0] lfsr_to_card(input logic [7:0] lfsr);
        logic [7:0] rank;
        rank = lfsr % 8'd13;
        if (rank >= 8'd9) return CARD_MAX;
        return rank[3:0] + 4'd1;
    endfunction

endpackage

// File: rtl/blackjack_game_fsm_card_source.sv
// Free-running LFSR card source with a test override for deterministic draws.
module card_source
    import blackjack_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] card_force,
    output logic [3:0] card
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Fibonacci taps 8,6,5,4 (bit numbers 7,5,4,3).
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end

    always_comb begin
        card = lfsr_to_card(lfsr_q);
        if (card_force != 4'd0) begin
            card = (card_force > CARD_MAX) ? CARD_MAX : card_force;
        end
    end

endmodule

// File: rtl/blackjack_game_fsm.sv
// Blackjack round control: deals cards, tracks totals, and requests LCD updates.
module blackjack_game_fsm
    import blackjack_pkg::*;
#(
    parameter logic [7:0] SEED         = 8'hA5,
    parameter int         DEALER_STAND = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       deal,
    input  logic       hit,
    input  logic       stand,
    input  logic [3:0] card_force,
    input  logic       end_lcd,
    output logic [4:0] hand,
    output logic [4:0] dealer_hand,
    output logic       defeat,
    output logic       victory,
    output logic       begin_s,
    output logic       busy
);

    localparam hand_t STAND_AT = hand_t'(DEALER_STAND);

    state_t     state_q, state_d;
    logic [1:0] deal_cnt_q, deal_cnt_d;
    hand_t      hand_q, hand_d;
    hand_t      dealer_q, dealer_d;
    logic       defeat_q, defeat_d;
    logic       victory_q, victory_d;
    logic       begin_q, begin_d;
    logic       busy_q, busy_d;
    logic       sync1_q, end_sync_q;
    logic [3:0] card;

    card_source #(.SEED(SEED)) u_card_source (
        .clk        (clk),
        .rst        (rst),
        .card_force (card_force),
        .card       (card)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            deal_cnt_q <= 2'd0;
            hand_q     <= '0;
            dealer_q   <= '0;
            defeat_q   <= 1'b0;
            victory_q  <= 1'b0;
            begin_q    <= 1'b0;
            busy_q     <= 1'b0;
            sync1_q    <= 1'b0;
            end_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            deal_cnt_q <= deal_cnt_d;
            hand_q     <= hand_d;
            dealer_q   <= dealer_d;
            defeat_q   <= defeat_d;
            victory_q  <= victory_d;
            begin_q    <= begin_d;
            busy_q     <= busy_d;
            sync1_q    <= end_lcd;
            end_sync_q <= sync1_q;
        end
    end

    // LCD req/ack: begin_s rises only once end_sync is low, stays high until
    // end_sync is seen high, then falls and the display phase is complete.
    always_comb begin
        state_d    = state_q;
        deal_cnt_d = deal_cnt_q;
        hand_d     = hand_q;
        dealer_d   = dealer_q;
        defeat_d   = defeat_q;
        victory_d  = victory_q;
        begin_d    = begin_q;

        case (state_q)
            S_IDLE: begin
                if (deal) begin
                    hand_d     = '0;
                    dealer_d   = '0;
                    defeat_d   = 1'b0;
                    victory_d  = 1'b0;
                    deal_cnt_d = 2'd0;
                    state_d    = S_DEAL;
                end
            end
            S_DEAL: begin
                deal_cnt_d = deal_cnt_q + 2'd1;
                if (deal_cnt_q == 2'd1) dealer_d = dealer_q + hand_t'(card);
                else                    hand_d   = hand_q + hand_t'(card);
                if (deal_cnt_q == 2'd2) state_d = S_CHECK;
            end
            S_PLAYER: begin
                if (stand)    state_d = S_DEALER;
                else if (hit) state_d = S_HIT;
            end
            S_HIT: begin
                hand_d  = hand_q + hand_t'(card);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (hand_q > BUST_LIMIT) begin
                    defeat_d = 1'b1;
                    state_d  = S_SHOW_END;
                end else if (hand_q == BUST_LIMIT) begin
                    victory_d = 1'b1;
                    state_d   = S_SHOW_END;
                end else begin
                    state_d = S_SHOW;
                end
            end
            S_SHOW, S_SHOW_END: begin
                if (!begin_q) begin
                    if (!end_sync_q) begin_d = 1'b1;
                end else if (end_sync_q) begin
                    begin_d = 1'b0;
                    state_d = (state_q == S_SHOW) ? S_PLAYER : S_IDLE;
                end
            end
            S_DEALER: begin
                if (dealer_q < STAND_AT) dealer_d = dealer_q + hand_t'(card);
                else                     state_d  = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (dealer_q > BUST_LIMIT || hand_q > dealer_q) victory_d = 1'b1;
                else if (hand_q < dealer_q)                      defeat_d  = 1'b1;
                state_d = S_SHOW_END;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = !(state_d == S_IDLE || state_d == S_PLAYER);
    end

    assign hand        = hand_q;
    assign dealer_hand = dealer_q;
    assign defeat      = defeat_q;
    assign victory     = victory_q;
    assign begin_s     = begin_q;
    assign busy        = busy_q;

endmodule

// File: doc/blackjack_game_fsm.md
# blackjack_game_fsm

Game-control stage for the blackjack design. It deals cards from an internal LFSR card source and keeps the player and dealer totals. It runs the hit/stand/dealer-draw sequence and drives the LCD controller with `hand`, `defeat`, `victory` and the `begin_s` update request. It consumes `end_lcd` from the LCD controller, so the two blocks form a request/acknowledge pair.

## Interface
Parameters:
- `SEED`, default 8'hA5: LFSR reset value; must be nonzero.
- `DEALER_STAND`, default 17: the dealer stops drawing once its total is ≥ this value.

Ports:
- `clk`, input, 1: system clock. This is the same clock that feeds the LCD controller's `clk2`.
- `rst`, input, 1: asynchronous, active-low reset.
- `deal`, input, 1: single-cycle pulse that starts a round.
- `hit`, input, 1: single-cycle pulse requesting one more player card.
- `stand`, input, 1: single-cycle pulse that ends the player's turn.
- `card_force`, input, 4: test hook. 0 means cards come from the LFSR; 1..10 means every drawn card has this value.
- `end_lcd`, input, 1: LCD controller "sequence finished" flag. It is asynchronous to the game FSM's timing and is synchronized internally.
- `hand`, output, 5: player total, 0..30.
- `dealer_hand`, output, 5: dealer total, 0..30. It is routed to LEDs only.
- `defeat`, output, 1: the round is lost.
- `victory`, output, 1: the round is won.
- `begin_s`, output, 1: LCD update request, held as a level.
- `busy`, output, 1: high whenever the FSM is not in `IDLE` or `PLAYER`.

## Operation
- Card source: an 8-bit Fibonacci LFSR with taps 8,6,5,4. It free-runs every cycle from reset.
  - rank = `lfsr mod 13` (0..12).
  - card value = min(rank+1, 10).
  - Ace counts as 1 and face cards count as 10.
- All totals are 5-bit unsigned. The maximum is 20+10 = 30, so the totals cannot overflow.
- FSM states:
  - `IDLE`: `deal` → `DEAL`. Clears `hand`, `dealer_hand`, `defeat` and `victory`.
  - `DEAL`: 3 cycles, drawing 1 card per cycle: player, dealer, player → `CHECK`.
  - `PLAYER`: waits for input.
    - `hit` → `HIT`.
    - `stand` → `DEALER`.
    - If `hit` and `stand` arrive in the same cycle, `stand` wins.
  - `HIT`: `hand += card` → `CHECK`.
  - `CHECK`:
    - `hand` > 21: `defeat`=1 → `SHOW_END`.
    - `hand` == 21: `victory`=1 → `SHOW_END`.
    - Otherwise → `SHOW`.
  - `SHOW`: update cycle (see handshake) → `PLAYER`.
  - `DEALER`:
    - While `dealer_hand` < `DEALER_STAND`, draw 1 card per cycle.
    - Otherwise → `RESOLVE`.
  - `RESOLVE`, one cycle:
    - `dealer_hand` > 21 or `hand` > `dealer_hand`: `victory`=1.
    - `hand` < `dealer_hand`: `defeat`=1.
    - Equal totals (push): both flags stay 0.
    - → `SHOW_END`.
  - `SHOW_END`: update cycle → `IDLE`.
- LCD handshake, used by both `SHOW` and `SHOW_END`:
  - `end_lcd` passes through a 2-flop synchronizer giving `end_sync`.
  - Before raising the request, wait until `end_sync`=0.
  - Raise `begin_s` and hold it until `end_sync`=1, then drop `begin_s`.
  - `hand`, `defeat` and `victory` are frozen from the moment `begin_s` rises until `begin_s` falls.
- `deal`, `hit` and `stand` pulses are ignored in every state other than the one that consumes them. They are not queued.
- `defeat` and `victory` are never both 1.
- `card_force` is sampled on the cycle the card is drawn. An out-of-range value (11..15) is treated as 10.

## Timing
- Reset values: `hand`=0, `dealer_hand`=0, `defeat`=0, `victory`=0, `begin_s`=0, `busy`=0, FSM in `IDLE`, LFSR=`SEED`, synchronizer flops=0.
- All outputs are registered, with no combinational path from input to output.
- Latencies:
  - `deal` to first `begin_s`: 5 cycles (DEAL ×3, CHECK, SHOW entry), provided `end_sync` is already 0.
  - `hit` to updated `hand`: 1 cycle after `HIT`. `begin_s` follows 2 cycles later.
  - `begin_s` fall: 1 cycle after `end_sync` rises, which is 3 `clk` after `end_lcd` rises.
- Reset mid-round or mid-handshake: everything returns to the reset values immediately. `begin_s` drops asynchronously.

## Structure
- Shared package `blackjack_pkg`:
  - FSM state encoding.
  - `BUST_LIMIT`=21.
  - `CARD_MAX`=10.
  - 5-bit total typedef `hand_t`.
- Sub-module `card_source`:
  - Contains the LFSR, the mod-13 mapping and the `card_force` mux.
  - Outputs a 4-bit `card`, valid every cycle.
- All other logic stays in the top-level module.

## Test plan
- Reset, `card_force`=5, `deal`:
  - `hand`=10, `dealer_hand`=5.
  - `begin_s` rises.
  - Model `end_lcd` rising 200 cycles later; `begin_s` falls 3 cycles after that.
- `card_force`=10, `deal`, `hit`: `hand`=30, `defeat`=1, `victory`=0, final update, `busy`=0 after the handshake.
- `card_force`=7, `deal`, `hit`: `hand`=21, `victory`=1 without any dealer draw, `dealer_hand`=7.
- `card_force`=9, `deal`, `stand`:
  - The dealer draws to 18 and the player holds 18, giving a push.
  - `defeat`=`victory`=0.
  - `SHOW_END` handshake completes.
- `hit` and `stand` pulsed in the same cycle while in `PLAYER`: treated as `stand` with no extra card. `hit` pulsed while `begin_s` is high: ignored, `hand` unchanged.
- Assert `rst` while `begin_s` is high during `DEALER` draws: all outputs go to 0 immediately. With `card_force`=0 after reset, the first dealt value matches the reference model of the `SEED`=8'hA5 LFSR.
